ddr3_frame_writer: RTL and testbench

Write-side counterpart of the DDR3 frame read path. Accepts a 24-bit pixel stream in the `mem_clk` domain and packs it bit-continuously into 256-bit words. Buffers the words and writes them to the DDR3 EMIF Avalon-MM port as fixed-length bursts. Used to load frames into DDR3 that the read path later replays to the display pipeline.

---
 rtl/ddr3_frame_writer_pkg.sv | 29 ++
 rtl/beat_fifo.sv | 51 +++++
 rtl/ddr3_frame_writer.sv | 197 +++++++++++++++++++
 tb/tb_ddr3_frame_writer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_frame_writer_pkg.sv
// Shared definitions for the DDR3 frame writer: pixel/beat geometry,
// the beat-boundary pixel indices of a 32-pixel group, and FSM encoding.
package ddr3_frame_writer_pkg;

    localparam int unsigned PIX_W         = 24;
    localparam int unsigned BEAT_W        = 256;
    localparam int unsigned PIX_PER_GROUP = 32;
    localparam int unsigned GRP_IDX_W     = $clog2(PIX_PER_GROUP);
    localparam int unsigned STRADDLE_0    = 10;
    localparam int unsigned STRADDLE_1    = 21;
    localparam int unsigned STRADDLE_2    = 31;
    // 32-bit pixel count * 3 / 32 needs at most 29 bits
    localparam int unsigned BEAT_CNT_W    = 29;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_BURST,
        ST_DONE
    } state_t;

    // True for the group pixels whose acceptance completes a 256-bit beat.
    function automatic logic beat_boundary(input logic [GRP_IDX_W-1:0] idx);
        return (idx == GRP_IDX_W'(STRADDLE_0)) ||
               (idx == GRP_IDX_W'(STRADDLE_1)) ||
               (idx == GRP_IDX_W'(STRADDLE_2));
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// Synchronous show-ahead FIFO for packed 256-bit beats.
// Ports: clk/rst_n, push + push_data (write), pop (read, head advances),
// head (current front entry, valid while count > 0), count (occupancy).
module beat_fifo
    import ddr3_frame_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [BEAT_W-1:0]         push_data,
    input  logic                      pop,
    output logic [BEAT_W-1:0]         head,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BEAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is not reset; head is only consumed while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ddr3_frame_writer.sv
// Packs a 24-bit pixel stream into 256-bit beats and writes them to the
// DDR3 EMIF Avalon-MM port as fixed-length bursts.
// Ports: mem_clk/mem_rst_n; start_in/start_addr_in/to_write_pix_in start a
// transfer; busy_out/write_done_out report status; pix_* is the pixel
// stream; ddr3_emif_* is the Avalon-MM write master.
// Optional macro DDR3_WR_TEST_PATTERN_EN replaces the pixel stream with an
// internal counter (pixel value = pixel index).
module ddr3_frame_writer
    import ddr3_frame_writer_pkg::*;
#(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] start_addr_in,
    input  logic [31:0]       to_write_pix_in,
    output logic              busy_out,
    output logic              write_done_out,
    input  logic [PIX_W-1:0]  pix_data_in,
    input  logic              pix_valid_in,
    output logic              pix_ready_out,
    input  logic              ddr3_emif_ready,
    output logic              ddr3_emif_write,
    output logic              ddr3_emif_read,
    output logic [ADDR_W-1:0] ddr3_emif_addr,
    output logic [BEAT_W-1:0] ddr3_emif_write_data,
    output logic [31:0]       ddr3_emif_byte_enable,
    output logic [4:0]        ddr3_emif_burst_count
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FILL_W = $clog2(BEAT_W);
    localparam int unsigned WIDE_W = BEAT_W + PIX_W;

    state_t                  state;
    logic                    pix_ok;
    logic [31:0]             pix_rem;
    logic [31:0]             pix_rem_next;
    logic [31:0]             pix_masked;
    logic [BEAT_CNT_W-1:0]   beats_total;
    logic [BEAT_CNT_W-1:0]   beats_rem;
    logic [4:0]              beat_cnt;
    logic [BEAT_W-1:0]       acc;
    logic [FILL_W-1:0]       fill;
    logic [GRP_IDX_W-1:0]    grp_idx;
    logic [WIDE_W-1:0]       wide;
    logic [PIX_W-1:0]        src_pix;
    logic                    src_valid;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    start_ok;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        count_next;
    logic [BEAT_W-1:0]       fifo_head;

`ifdef DDR3_WR_TEST_PATTERN_EN
    logic [PIX_W-1:0] tp_pix;

    assign src_pix       = tp_pix;
    assign src_valid     = 1'b1;
    assign pix_ready_out = 1'b0;

    // Test-pattern source: value equals pixel index, restarts on each start.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            tp_pix <= '0;
        end else if (start_ok) begin
            tp_pix <= '0;
        end else if (accept) begin
            tp_pix <= tp_pix + PIX_W'(1);
        end
    end
`else
    assign src_pix       = pix_data_in;
    assign src_valid     = pix_valid_in;
    assign pix_ready_out = pix_ok;
`endif

    assign ddr3_emif_read        = 1'b0;
    assign ddr3_emif_byte_enable = '1;
    assign ddr3_emif_write_data  = ddr3_emif_write ? fifo_head : '0;

    // Beat count = (pix / 32) * 3 = (pix >> 4) + (pix >> 5) once the low bits are cleared.
    assign pix_masked  = to_write_pix_in & ~32'h1F;
    assign beats_total = BEAT_CNT_W'(pix_masked >> 4) + BEAT_CNT_W'(pix_masked >> 5);

    // Packer datapath: new pixel lands at the running bit offset; bits past 255 carry over.
    always_comb begin
        start_ok     = (state == ST_IDLE) && start_in;
        accept       = pix_ok && src_valid;
        wide         = {{PIX_W{1'b0}}, acc} | (WIDE_W'(src_pix) << fill);
        push         = accept && beat_boundary(grp_idx);
        pop          = (state == ST_BURST) && ddr3_emif_ready;
        count_next   = fifo_count + CNT_W'(push) - CNT_W'(pop);
        pix_rem_next = start_ok ? pix_masked : (pix_rem - 32'(accept));
    end

    beat_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (mem_clk),
        .rst_n     (mem_rst_n),
        .push      (push),
        .push_data (wide[BEAT_W-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Control FSM, packer state and registered outputs.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state                 <= ST_IDLE;
            busy_out              <= 1'b0;
            write_done_out        <= 1'b0;
            ddr3_emif_write       <= 1'b0;
            ddr3_emif_addr        <= '0;
            ddr3_emif_burst_count <= '0;
            beats_rem             <= '0;
            beat_cnt              <= '0;
            pix_rem               <= '0;
            pix_ok                <= 1'b0;
            acc                   <= '0;
            fill                  <= '0;
            grp_idx               <= '0;
        end else begin
            pix_rem <= pix_rem_next;
            // Registered ready from next-cycle values keeps one slot of FIFO margin.
            pix_ok  <= (count_next <= CNT_W'(FIFO_DEPTH - 2)) && (pix_rem_next != '0);

            if (accept) begin
                fill    <= fill + FILL_W'(PIX_W);
                grp_idx <= grp_idx + GRP_IDX_W'(1);
                acc     <= push ? BEAT_W'(wide[WIDE_W-1:BEAT_W]) : wide[BEAT_W-1:0];
            end

            case (state)
                ST_IDLE: begin
                    write_done_out <= 1'b0;
                    if (start_in) begin
                        ddr3_emif_addr <= start_addr_in;
                        beats_rem      <= beats_total;
                        acc            <= '0;
                        fill           <= '0;
                        grp_idx        <= '0;
                        if (beats_total == '0) begin
                            state          <= ST_DONE;
                            write_done_out <= 1'b1;
                        end else begin
                            state    <= ST_FILL;
                            busy_out <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if ((fifo_count >= CNT_W'(BURST_LEN)) ||
                        ((pix_rem == '0) && (fifo_count != '0))) begin
                        state                 <= ST_BURST;
                        ddr3_emif_write       <= 1'b1;
                        beat_cnt              <= '0;
                        ddr3_emif_burst_count <= (beats_rem < BEAT_CNT_W'(BURST_LEN)) ?
                                                 5'(beats_rem) : 5'(BURST_LEN);
                    end
                end
                ST_BURST: begin
                    if (ddr3_emif_ready) begin
                        beats_rem <= beats_rem - BEAT_CNT_W'(1);
                        beat_cnt  <= beat_cnt + 5'd1;
                        if (beat_cnt == ddr3_emif_burst_count - 5'd1) begin
                            ddr3_emif_write <= 1'b0;
                            ddr3_emif_addr  <= ddr3_emif_addr + ADDR_W'(ddr3_emif_burst_count);
                            if (beats_rem == BEAT_CNT_W'(1)) begin
                                state          <= ST_DONE;
                                write_done_out <= 1'b1;
                                busy_out       <= 1'b0;
                            end else begin
                                state <= ST_FILL;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    write_done_out <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Self-checking bench for ddr3_frame_writer: directed transfers with an
// independent 768-bit group packing model and an EMIF beat scoreboard.
module tb_ddr3_frame_writer;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned FIFO_DEPTH = 32;

    logic              mem_clk = 1'b0;
    logic              mem_rst_n;
    logic              start_in;
    logic [ADDR_W-1:0] start_addr_in;
    logic [31:0]       to_write_pix_in;
    logic              busy_out;
    logic              write_done_out;
    logic [23:0]       pix_data_in;
    logic              pix_valid_in;
    logic              pix_ready_out;
    logic              ddr3_emif_ready = 1'b1;
    logic              ddr3_emif_write;
    logic              ddr3_emif_read;
    logic [ADDR_W-1:0] ddr3_emif_addr;
    logic [255:0]      ddr3_emif_write_data;
    logic [31:0]       ddr3_emif_byte_enable;
    logic [4:0]        ddr3_emif_burst_count;

    always #5 mem_clk = ~mem_clk;

    ddr3_frame_writer #(
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .mem_clk               (mem_clk),
        .mem_rst_n             (mem_rst_n),
        .start_in              (start_in),
        .start_addr_in         (start_addr_in),
        .to_write_pix_in       (to_write_pix_in),
        .busy_out              (busy_out),
        .write_done_out        (write_done_out),
        .pix_data_in           (pix_data_in),
        .pix_valid_in          (pix_valid_in),
        .pix_ready_out         (pix_ready_out),
        .ddr3_emif_ready       (ddr3_emif_ready),
        .ddr3_emif_write       (ddr3_emif_write),
        .ddr3_emif_read        (ddr3_emif_read),
        .ddr3_emif_addr        (ddr3_emif_addr),
        .ddr3_emif_write_data  (ddr3_emif_write_data),
        .ddr3_emif_byte_enable (ddr3_emif_byte_enable),
        .ddr3_emif_burst_count (ddr3_emif_burst_count)
    );

    int passed;
    int total;

    logic [255:0]      exp_q[$];
    logic [255:0]      got_q[$];
    logic [ADDR_W-1:0] b_addr_q[$];
    logic [4:0]        b_cnt_q[$];

    int          done_cnt;
    int          stall_viol;
    int          stall_seen;
    int          sent;
    int          target;
    int          n_acc;
    int          first_acc;
    int          last_acc;
    int          cyc;
    logic [23:0] pix_base;
    bit          stall_mode;

    // EMIF ready source: always high, or repeating 1-0-0-1 in stall mode.
    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = 0;
        forever begin
            @(posedge mem_clk);
            #1;
            cyc++;
            ddr3_emif_ready = stall_mode ? pat[cyc % 4] : 1'b1;
        end
    end

    // Pixel source: value = pix_base + index, offered back-to-back.
    initial begin
        pix_valid_in = 1'b0;
        pix_data_in  = '0;
        forever begin
            @(negedge mem_clk);
            if (pix_valid_in && pix_ready_out) begin
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
                n_acc++;
            end
            @(posedge mem_clk);
            #1;
            if (sent < target) begin
                pix_valid_in = 1'b1;
                pix_data_in  = pix_base + 24'(sent);
            end else begin
                pix_valid_in = 1'b0;
                pix_data_in  = '0;
            end
        end
    end

    // EMIF monitor: collects accepted beats, burst headers, stall stability.
    initial begin
        logic              prev_write;
        logic              hold_valid;
        logic [255:0]      hold_data;
        logic [ADDR_W-1:0] hold_addr;
        logic [4:0]        hold_bc;
        prev_write = 1'b0;
        hold_valid = 1'b0;
        hold_data  = '0;
        hold_addr  = '0;
        hold_bc    = '0;
        forever begin
            @(negedge mem_clk);
            if (mem_rst_n !== 1'b1) begin
                prev_write = 1'b0;
                hold_valid = 1'b0;
                continue;
            end
            if (ddr3_emif_write) begin
                if (!prev_write) begin
                    b_addr_q.push_back(ddr3_emif_addr);
                    b_cnt_q.push_back(ddr3_emif_burst_count);
                end
                if (hold_valid && (ddr3_emif_write_data !== hold_data ||
                                   ddr3_emif_addr !== hold_addr ||
                                   ddr3_emif_burst_count !== hold_bc)) begin
                    stall_viol++;
                end
                if (ddr3_emif_ready) begin
                    got_q.push_back(ddr3_emif_write_data);
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = ddr3_emif_write_data;
                    hold_addr  = ddr3_emif_addr;
                    hold_bc    = ddr3_emif_burst_count;
                    stall_seen++;
                end
            end else begin
                hold_valid = 1'b0;
            end
            prev_write = ddr3_emif_write;
            if (write_done_out) done_cnt++;
        end
    end

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        b_addr_q.delete();
        b_cnt_q.delete();
        done_cnt   = 0;
        stall_viol = 0;
        stall_seen = 0;
    endtask

    // Reference packing: 32 pixels little-endian in 768 bits, split in 3 beats.
    task automatic build_expected(input int n, input logic [23:0] b);
        logic [767:0] grp;
        exp_q.delete();
        for (int g = 0; g < n / 32; g++) begin
            for (int i = 0; i < 32; i++) grp[24*i +: 24] = b + 24'(g * 32 + i);
            for (int j = 0; j < 3; j++) exp_q.push_back(grp[256*j +: 256]);
        end
    endtask

    task automatic start_xfer(input int n_drive, input logic [31:0] n_field,
                              input logic [ADDR_W-1:0] a, input logic [23:0] b);
        @(negedge mem_clk);
        #2;
        sent     = 0;
        n_acc    = 0;
        target   = n_drive;
        pix_base = b;
        @(posedge mem_clk);
        #1;
        start_in        = 1'b1;
        start_addr_in   = a;
        to_write_pix_in = n_field;
        @(posedge mem_clk);
        #1;
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge mem_clk);
            #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge mem_clk);
    endtask

    task automatic test_reset();
        mem_rst_n = 1'b0;
        repeat (3) @(posedge mem_clk);
        @(negedge mem_clk);
        total++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy_out); else passed++;
        total++; if (write_done_out !== 1'b0) $display("FAIL reset_done: got %b, expected 0", write_done_out); else passed++;
        total++; if (ddr3_emif_write !== 1'b0) $display("FAIL reset_write: got %b, expected 0", ddr3_emif_write); else passed++;
        total++; if (ddr3_emif_read !== 1'b0) $display("FAIL reset_read: got %b, expected 0", ddr3_emif_read); else passed++;
        total++; if (ddr3_emif_addr !== '0) $display("FAIL reset_addr: got %h, expected 0", ddr3_emif_addr); else passed++;
        total++; if (ddr3_emif_burst_count !== 5'd0) $display("FAIL reset_bcount: got %0d, expected 0", ddr3_emif_burst_count); else passed++;
        total++; if (ddr3_emif_byte_enable !== 32'hFFFF_FFFF) $display("FAIL reset_be: got %h, expected ffffffff", ddr3_emif_byte_enable); else passed++;
        total++; if (pix_ready_out !== 1'b0) $display("FAIL reset_pix_ready: got %b, expected 0", pix_ready_out); else passed++;
        total++; if (ddr3_emif_write_data !== '0) $display("FAIL reset_wdata: got %h, expected 0", ddr3_emif_write_data); else passed++;
        @(posedge mem_clk);
        #1;
        mem_rst_n = 1'b1;
        repeat (2) @(posedge mem_clk);
    endtask

    task automatic test_single_group();
        bit           ok;
        logic [255:0] b0;
        clear_sb();
        build_expected(32, 24'h0);
        start_xfer(32, 32'd32, 25'h100, 24'h0);
        wait_done(400, ok);
        total++; if (!ok) $display("FAIL single_done_timeout: got no done, expected done"); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL single_done_count: got %0d, expected 1", done_cnt); else passed++;
        total++; if (got_q.size() != 3) $display("FAIL single_beats: got %0d, expected 3", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL single_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++;
        if (b_addr_q.size() != 1 || b_addr_q[0] !== 25'h100 || b_cnt_q[0] !== 5'd3)
            $display("FAIL single_burst: got %0d bursts, expected one at 100 len 3", b_addr_q.size());
        else passed++;
        if (got_q.size() > 0) begin
            b0 = got_q[0];
            total++; if (b0[23:0] !== 24'h0) $display("FAIL single_pix0: got %h, expected 000000", b0[23:0]); else passed++;
            total++; if (b0[255:240] !== 16'h000A) $display("FAIL single_pix10_lo: got %h, expected 000a", b0[255:240]); else passed++;
        end
        total++; if (busy_out !== 1'b0) $display("FAIL single_busy_end: got %b, expected 0", busy_out); else passed++;
    endtask

    task automatic test_full_bursts();
        bit                ok;
        logic [ADDR_W-1:0] a;
        a = 25'h1000;
        clear_sb();
        build_expected(512, 24'h123456);
        start_xfer(512, 32'd512, a, 24'h123456);
        wait_done(2000, ok);
        total++; if (!ok) $display("FAIL full_done_timeout: got no done, expected done"); else passed++;
        total++; if (got_q.size() != 48) $display("FAIL full_beats: got %0d, expected 48", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL full_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++; if (b_addr_q.size() != 3) $display("FAIL full_nbursts: got %0d, expected 3", b_addr_q.size()); else passed++;
        for (int k = 0; k < 3 && k < b_addr_q.size(); k++) begin
            total++;
            if (b_addr_q[k] !== a + ADDR_W'(16 * k) || b_cnt_q[k] !== 5'd16)
                $display("FAIL full_burst%0d: got addr %h len %0d, expected addr %h len 16", k, b_addr_q[k], b_cnt_q[k], a + ADDR_W'(16 * k));
            else passed++;
        end
        total++; if (n_acc != 512) $display("FAIL full_pix_count: got %0d, expected 512", n_acc); else passed++;
        total++; if (last_acc - first_acc + 1 != 512) $display("FAIL full_throughput: got %0d cycles, expected 512", last_acc - first_acc + 1); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL full_done_count: got %0d, expected 1", done_cnt); else passed++;
    endtask

    task automatic test_partial_burst();
        bit                ok;
        logic [ADDR_W-1:0] a;
        logic [4:0]        exp_len [3];
        exp_len = '{5'd16, 5'd16, 5'd1};
        a = 25'h2000;
        clear_sb();
        build_expected(352, 24'hABC000);
        start_xfer(352, 32'd352, a, 24'hABC000);
        wait_done(2000, ok);
        total++; if (!ok) $display("FAIL partial_done_timeout: got no done, expected done"); else passed++;
        total++; if (got_q.size() != 33) $display("FAIL partial_beats: got %0d, expected 33", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL partial_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++; if (b_addr_q.size() != 3) $display("FAIL partial_nbursts: got %0d, expected 3", b_addr_q.size()); else passed++;
        for (int k = 0; k < 3 && k < b_addr_q.size(); k++) begin
            total++;
            if (b_addr_q[k] !== a + ADDR_W'(16 * k) || b_cnt_q[k] !== exp_len[k])
                $display("FAIL partial_burst%0d: got addr %h len %0d, expected addr %h len %0d", k, b_addr_q[k], b_cnt_q[k], a + ADDR_W'(16 * k), exp_len[k]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        bit                ok;
        logic [ADDR_W-1:0] a;
        a = 25'h3000;
        clear_sb();
        build_expected(192, 24'h0F0F00);
        stall_mode = 1'b1;
        start_xfer(192, 32'd192, a, 24'h0F0F00);
        wait_done(2000, ok);
        stall_mode = 1'b0;
        total++; if (!ok) $display("FAIL stall_done_timeout: got no done, expected done"); else passed++;
        total++; if (got_q.size() != 18) $display("FAIL stall_beats: got %0d, expected 18", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL stall_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++; if (stall_seen == 0) $display("FAIL stall_exercised: got 0 stall cycles, expected some"); else passed++;
        total++; if (stall_viol != 0) $display("FAIL stall_hold: got %0d unstable cycles, expected 0", stall_viol); else passed++;
        total++;
        if (b_addr_q.size() != 2 || b_addr_q[0] !== a || b_cnt_q[0] !== 5'd16 ||
            b_addr_q[1] !== a + ADDR_W'(16) || b_cnt_q[1] !== 5'd2)
            $display("FAIL stall_bursts: got %0d bursts, expected 16@%h and 2@%h", b_addr_q.size(), a, a + ADDR_W'(16));
        else passed++;
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_sb();
        build_expected(64, 24'h000500);
        start_xfer(64, 32'd64, 25'h300, 24'h000500);
        repeat (5) @(posedge mem_clk);
        #1;
        start_in        = 1'b1;
        start_addr_in   = 25'h1ABCD;
        to_write_pix_in = 32'd320;
        @(posedge mem_clk);
        #1;
        start_in = 1'b0;
        wait_done(1000, ok);
        total++; if (!ok) $display("FAIL busy_done_timeout: got no done, expected done"); else passed++;
        total++; if (got_q.size() != 6) $display("FAIL busy_beats: got %0d, expected 6", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL busy_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++;
        if (b_addr_q.size() != 1 || b_addr_q[0] !== 25'h300 || b_cnt_q[0] !== 5'd6)
            $display("FAIL busy_burst: got %0d bursts, expected one at 300 len 6", b_addr_q.size());
        else passed++;
        repeat (40) @(negedge mem_clk);
        total++; if (busy_out !== 1'b0) $display("FAIL busy_after: got %b, expected 0", busy_out); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL busy_done_count: got %0d, expected 1", done_cnt); else passed++;
        total++; if (n_acc != 64) $display("FAIL busy_pix_count: got %0d, expected 64", n_acc); else passed++;
    endtask

    task automatic test_zero_count();
        bit ok;
        clear_sb();
        start_xfer(0, 32'd31, 25'h700, 24'h0);
        wait_done(10, ok);
        total++; if (!ok) $display("FAIL zero_done_timeout: got no done, expected done"); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL zero_done_count: got %0d, expected 1", done_cnt); else passed++;
        total++; if (got_q.size() != 0) $display("FAIL zero_beats: got %0d, expected 0", got_q.size()); else passed++;
        total++; if (busy_out !== 1'b0) $display("FAIL zero_busy: got %b, expected 0", busy_out); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clear_sb();
        start_xfer(512, 32'd512, 25'h4000, 24'h777000);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge mem_clk);
            #1;
            if (ddr3_emif_write && got_q.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) $display("FAIL rstmid_reach_burst: got no burst, expected burst"); else passed++;
        @(posedge mem_clk);
        #3;
        mem_rst_n = 1'b0;
        #1;
        total++; if (ddr3_emif_write !== 1'b0) $display("FAIL rstmid_write: got %b, expected 0", ddr3_emif_write); else passed++;
        total++; if (busy_out !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy_out); else passed++;
        total++; if (ddr3_emif_addr !== '0) $display("FAIL rstmid_addr: got %h, expected 0", ddr3_emif_addr); else passed++;
        total++; if (ddr3_emif_burst_count !== 5'd0) $display("FAIL rstmid_bcount: got %0d, expected 0", ddr3_emif_burst_count); else passed++;
        total++; if (pix_ready_out !== 1'b0) $display("FAIL rstmid_pix_ready: got %b, expected 0", pix_ready_out); else passed++;
        total++; if (ddr3_emif_write_data !== '0) $display("FAIL rstmid_wdata: got %h, expected 0", ddr3_emif_write_data); else passed++;
        target = 0;
        repeat (4) @(posedge mem_clk);
        #1;
        mem_rst_n = 1'b1;
        repeat (6) @(negedge mem_clk);
        total++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d, expected 0", done_cnt); else passed++;
        clear_sb();
        build_expected(32, 24'h00AA00);
        start_xfer(32, 32'd32, 25'h500, 24'h00AA00);
        wait_done(400, ok);
        total++; if (!ok) $display("FAIL rstmid_after_timeout: got no done, expected done"); else passed++;
        total++; if (got_q.size() != 3) $display("FAIL rstmid_after_beats: got %0d, expected 3", got_q.size()); else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) $display("FAIL rstmid_after_beat%0d: got %h, expected %h", k, got_q[k], exp_q[k]); else passed++;
        end
        total++;
        if (b_addr_q.size() != 1 || b_addr_q[0] !== 25'h500 || b_cnt_q[0] !== 5'd3)
            $display("FAIL rstmid_after_burst: got %0d bursts, expected one at 500 len 3", b_addr_q.size());
        else passed++;
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        sent            = 0;
        target          = 0;
        n_acc           = 0;
        first_acc       = 0;
        last_acc        = 0;
        pix_base        = '0;
        stall_mode      = 1'b0;
        done_cnt        = 0;
        stall_viol      = 0;
        stall_seen      = 0;
        mem_rst_n       = 1'b0;
        start_in        = 1'b0;
        start_addr_in   = '0;
        to_write_pix_in = '0;
        test_reset();
        test_single_group();
        test_full_bursts();
        test_partial_burst();
        test_stall();
        test_start_busy();
        test_zero_count();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
